// File: rtl/strela_stream_pkg.sv
// Shared types and widths for the strided memory-to-stream reader.
package strela_stream_pkg;

    localparam int WORD_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int LEN_W    = 16;
    localparam int STRIDE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FLUSH
    } stream_state_e;

endpackage

// File: rtl/stream_word_fifo.sv
// Small first-word-fall-through FIFO buffering memory responses for the stream output.
module stream_word_fifo
    import strela_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop_i && (count != '0);
    // A push at full is only safe when the head leaves in the same cycle.
    assign do_push = push_i && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign empty_o = (count == '0);
    assign rdata_o = empty_o ? '0 : mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/input_stream_reader.sv
// Strided memory reader: issues credit-limited read requests and streams the
// returned words, in order, to a CGRA input node.
module input_stream_reader
    import strela_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                clear_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [LEN_W-1:0]    size_i,
    input  logic [STRIDE_W-1:0] stride_i,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [WORD_W-1:0]   mem_rdata_i,
    output logic [WORD_W-1:0]   data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    stream_state_e        state;
    logic [ADDR_W-1:0]    addr_reg;
    logic [STRIDE_W-1:0]  stride_reg;
    logic [LEN_W-1:0]     words_left;
    logic [CNT_W-1:0]     outstanding;
    logic                 req_reg;
    logic                 done_reg;

    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_empty;
    logic                 active;
    logic                 grant;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic [CNT_W-1:0]     outstanding_next;
    logic [CNT_W-1:0]     fifo_count_next;
    logic [LEN_W-1:0]     words_left_next;
    logic [SUM_W-1:0]     credit_next;
    logic                 req_next_run;

    // The request is registered, so the credit test looks at next-cycle
    // occupancy: in-flight reads plus buffered words never exceed the FIFO.
    always_comb begin
        active           = (state == ST_RUN) || (state == ST_DRAIN);
        grant            = req_reg && mem_gnt_i;
        flush            = active && clear_i;
        push             = active && !clear_i && mem_rvalid_i;
        pop              = !fifo_empty && ready_i;
        outstanding_next = outstanding + CNT_W'(grant)
                         - CNT_W'(mem_rvalid_i && (outstanding != '0));
        fifo_count_next  = flush ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));
        words_left_next  = words_left - LEN_W'(grant);
        credit_next      = SUM_W'(outstanding_next) + SUM_W'(fifo_count_next);
        req_next_run     = (words_left_next != '0) && (credit_next < SUM_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            addr_reg    <= '0;
            stride_reg  <= '0;
            words_left  <= '0;
            outstanding <= '0;
            req_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            outstanding <= outstanding_next;
            case (state)
                ST_IDLE: begin
                    if (start_i && !clear_i) begin
                        addr_reg   <= addr_i;
                        stride_reg <= stride_i;
                        words_left <= size_i;
                        if (size_i == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            req_reg <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (clear_i) begin
                        state   <= ST_FLUSH;
                        req_reg <= 1'b0;
                    end else begin
                        words_left <= words_left_next;
                        req_reg    <= req_next_run;
                        if (grant) begin
                            addr_reg <= addr_reg + ADDR_W'(stride_reg);
                        end
                        if (grant && (words_left_next == '0)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (clear_i) begin
                        state <= ST_FLUSH;
                    end else if ((outstanding == '0) && fifo_empty) begin
                        state    <= ST_IDLE;
                        done_reg <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Responses still in flight are absorbed here and dropped.
                    if (outstanding == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    stream_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (mem_rdata_i),
        .pop_i   (pop),
        .rdata_o (data_o),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign mem_req_o  = req_reg;
    assign mem_addr_o = addr_reg;
    assign valid_o    = !fifo_empty;
    assign busy_o     = (state != ST_IDLE);
    assign done_o     = done_reg;

endmodule
